// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data lines.
// Optional transfer watchdog: define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int INH_CYC = (CLK_FREQ / 1_000_000) * INHIBIT_US;
  localparam int IW      = $clog2(INH_CYC + 2);
  localparam logic [IW-1:0] INH_LD =
    IW'(INH_CYC > 0 ? INH_CYC - 1 : 0);
  localparam int WD_LIM  = (CLK_FREQ / 1000) * TIMEOUT_MS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_RELEASE,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    clk_s_q;
  logic [1:0]    dat_s_q;
  logic          clk_prev_q;
  logic [7:0]    data_q;
  logic          par_q;
  logic [IW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic          ready_q;
  logic          clk_oe_q;
  logic          dat_oe_q;
  logic          done_q;
  logic          ack_q;

  logic clk_sync;
  logic dat_sync;
  logic fall;
  logic wd_exp;

  assign clk_sync = clk_s_q[1];
  assign dat_sync = dat_s_q[1];
  assign fall     = clk_prev_q & ~clk_sync;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WW = $clog2(WD_LIM + 2);

  logic [WW-1:0] wd_q;
  logic          err_q;
  logic          in_xfer;

  assign in_xfer = (state_q == S_SHIFT) ||
                   (state_q == S_ACK) ||
                   (state_q == S_RELEASE);
  assign wd_exp  = in_xfer && (wd_q >= WW'(WD_LIM - 1));
  assign tx_error = err_q;

  // REQUEST counts as the first watchdog cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= wd_exp;
      if (state_q == S_REQUEST) begin
        wd_q <= WW'(1);
      end else if (in_xfer && !wd_exp) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end
`else
  logic unused_wd;

  assign wd_exp    = 1'b0;
  assign unused_wd = ^WD_LIM;
  assign tx_error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
      data_q     <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      ready_q    <= 1'b1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk_in};
      dat_s_q    <= {dat_s_q[0], ps2_data_in};
      clk_prev_q <= clk_sync;
      if (wd_exp) begin
        state_q  <= S_IDLE;
        ready_q  <= 1'b1;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tx_valid) begin
              data_q   <= tx_data;
              par_q    <= ~^tx_data;
              cnt_q    <= INH_LD;
              ack_q    <= 1'b0;
              ready_q  <= 1'b0;
              clk_oe_q <= 1'b1;
              state_q  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q <= IW'(1)) begin
              dat_oe_q <= 1'b1;
              state_q  <= S_REQUEST;
            end
          end
          S_REQUEST: begin
            clk_oe_q <= 1'b0;
            bit_q    <= '0;
            state_q  <= S_SHIFT;
          end
          S_SHIFT: begin
            if (fall) begin
              bit_q <= bit_q + 1'b1;
              unique case (1'b1)
                bit_q < 4'd8:
                  dat_oe_q <= ~data_q[bit_q[2:0]];
                bit_q == 4'd8:
                  dat_oe_q <= ~par_q;
                default: begin
                  dat_oe_q <= 1'b0;
                  state_q  <= S_ACK;
                end
              endcase
            end
          end
          S_ACK: begin
            if (fall) begin
              ack_q   <= ~dat_sync;
              state_q <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (clk_sync && dat_sync) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            ready_q  <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = dat_oe_q;
  assign tx_done     = done_q;
  assign tx_ack_ok   = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the wired lines, frame scoreboard.
// Define PS2_HOST_TX_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;
  logic       dev_clk;
  logic       dev_data;
  logic       err_seen;
  int         n_chk;
  int         n_fail;
  exp_t       sb[$];

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ  (1_000_000),
    .INHIBIT_US(100),
    .TIMEOUT_MS(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_ack_ok  (tx_ack_ok),
    .tx_error   (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_error === 1'b1) err_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic push_exp(input logic [7:0] b, input logic ack);
    exp_t e;
    e.d   = b;
    e.par = odd_par(b);
    e.ack = ack;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic ack,
                      input bit push);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    if (push) push_exp(b, ack);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  // device side: 20-cycle clock period, samples in the low phase
  task automatic dev_frame(input bit ack_en, input int abort_at);
    int         n;
    logic [9:0] bits;
    exp_t       e;
    bits = '0;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ps2_clk_oe && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, 100);
    check("start_bit", ps2_data_in, 1'b0);
    check("busy_ready", tx_ready, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      repeat (5) @(negedge clk);
      if (i == 11 && ack_en) dev_data = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2_data_in;
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_done", tx_done, 1'b0);
        check("rst_ack", tx_ack_ok, 1'b0);
        dev_clk = 1'b1;
        if (sb.size() > 0) void'(sb.pop_front());
        return;
      end
      repeat (5) @(negedge clk);
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
    end
    n = 0;
    while (!tx_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", tx_done, 1'b1);
    check("sb_size", sb.size(), 1 + (sb.size() > 1 ? sb.size() - 1 : 0));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data_bits", bits[7:0], e.d);
      check("parity_bit", bits[8], e.par);
      check("stop_bit", bits[9], 1'b1);
      check("ack_ok", tx_ack_ok, e.ack);
    end else begin
      check("sb_nonempty", sb.size(), 1);
    end
    @(negedge clk);
    check("done_pulse", tx_done, 1'b0);
    check("ready_back", tx_ready, 1'b1);
  endtask

  initial begin
    int n;
    logic done_flag;
    n_chk    = 0;
    n_fail   = 0;
    err_seen = 1'b0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset_done", tx_done, 1'b0);
    check("reset_ack", tx_ack_ok, 1'b0);
    check("reset_err", tx_error, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hED, 1'b1, 1'b1);
    dev_frame(1'b1, 0);
    send(8'h00, 1'b1, 1'b1);
    dev_frame(1'b1, 0);
    send(8'hFF, 1'b1, 1'b1);
    dev_frame(1'b1, 0);
    send(8'h3C, 1'b0, 1'b1);
    dev_frame(1'b0, 0);

    fork
      begin
        int k;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        push_exp(8'hA3, 1'b1);
        repeat (60) @(negedge clk);
        tx_data = 8'h55;
        push_exp(8'h55, 1'b1);
        k = 0;
        while (!tx_done && k < 1000) begin
          @(negedge clk);
          k++;
        end
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        dev_frame(1'b1, 0);
        dev_frame(1'b1, 0);
      end
    join

    repeat (3) @(negedge clk);
    send(8'hED, 1'b1, 1'b1);
    dev_frame(1'b1, 5);
    repeat (5) @(negedge clk);
    send(8'hF4, 1'b1, 1'b1);
    dev_frame(1'b1, 0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    repeat (3) @(negedge clk);
    send(8'h12, 1'b0, 1'b0);
    n = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wd_request", ps2_data_oe, 1'b1);
    n = 0;
    done_flag = 1'b0;
    while (!tx_error && n < 2000) begin
      @(negedge clk);
      n++;
      if (tx_done) done_flag = 1'b1;
    end
    check("wd_cycles", n, 1000);
    check("wd_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("wd_no_done", done_flag, 1'b0);
    @(negedge clk);
    check("wd_pulse", tx_error, 1'b0);
    check("wd_ready", tx_ready, 1'b1);
    check("wd_err_seen", err_seen, 1'b1);
`else
    n = 0;
    done_flag = 1'b0;
    check("no_error", err_seen, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time in microseconds.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15, transfer watchdog limit in milliseconds (used only under REQ-029).
REQ-004 SHALL have port clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port tx_data  input  8  byte to send to the device.
REQ-007 SHALL have port tx_valid  input  1  send request.
REQ-008 SHALL have port tx_ready  output  1  high when a request will be accepted.
REQ-009 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line level.
REQ-010 SHALL have port ps2_data_in  input  1  raw PS/2 data line level.
REQ-011 SHALL have port ps2_clk_oe  output  1  1 = pull the clock line low (open-drain), 0 = release it.
REQ-012 SHALL have port ps2_data_oe  output  1  1 = pull the data line low, 0 = release it.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse when a frame completes.
REQ-014 SHALL have port tx_ack_ok  output  1  device acknowledge result; valid while tx_done is high.
REQ-015 SHALL have port tx_error  output  1  one-cycle pulse on watchdog abort.

Function
REQ-016 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers.
- A clock falling edge is: synchronized clock was 1 on the previous cycle and is 0 now.
REQ-017 SHALL implement the states IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE and DONE.
REQ-018 IDLE: tx_ready=1 and both oe=0.
- When tx_valid=1 in IDLE: latch tx_data, latch parity = ~^tx_data (odd parity), load the inhibit counter with (CLK_FREQ/1_000_000)*INHIBIT_US-1, and go to INHIBIT.
- tx_ready SHALL drop in the next cycle.
REQ-019 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0.
- The counter decrements each cycle; when it reaches 0, go to REQUEST.
REQ-020 REQUEST lasts exactly one cycle: ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0); then go to SHIFT.
REQ-021 SHIFT: ps2_clk_oe=0. The 4-bit bit counter starts at 0 and increments on each clock falling edge.
- After falling edge n, for n=1..8: ps2_data_oe = ~tx_data[n-1] (LSB first).
- After edge 9: ps2_data_oe = ~parity.
- After edge 10: ps2_data_oe=0 (stop bit 1), and go to ACK.
REQ-022 ACK: on the next falling edge (edge 11), capture tx_ack_ok = ~synchronized data, then go to RELEASE.
REQ-023 RELEASE: wait until the synchronized clock and data are both 1, then go to DONE.
REQ-024 DONE lasts one cycle: tx_done=1, then go to IDLE.
- tx_ack_ok SHALL hold its value until the next frame is accepted.
REQ-025 While not in IDLE, tx_valid SHALL be ignored.
- tx_data changing mid-frame SHALL have no effect.
REQ-026 A missing acknowledge (data high at edge 11) SHALL still complete the frame with tx_done=1 and tx_ack_ok=0.
REQ-027 Device clock edges arriving during INHIBIT or REQUEST SHALL be ignored.

Reset
REQ-028 When rst_n=0 at a clock edge, the following values SHALL apply from the next cycle, including mid-frame:
- state=IDLE, tx_ready=1;
- ps2_clk_oe=0, ps2_data_oe=0 (lines released);
- tx_done=0, tx_ack_ok=0, tx_error=0;
- all counters and synchronizers cleared to idle-high (synchronizer outputs 1).

Configuration
REQ-029 With macro PS2_HOST_TX_TIMEOUT_EN defined, a watchdog SHALL run as follows.
- It starts at REQUEST and counts up to (CLK_FREQ/1000)*TIMEOUT_MS cycles while in SHIFT, ACK or RELEASE.
- On expiry: release both lines, pulse tx_error for one cycle, do not assert tx_done, and return to IDLE.
- Without the macro there is no watchdog: tx_error SHALL be tied to 0, and the block waits indefinitely for device edges.

Verification
REQ-030 The bench SHALL cover these directed scenarios (CLK_FREQ=1_000_000, INHIBIT_US=100; the device model clocks at a 20 us period and drives ack low at edge 11):
- Send 0xED -> clk_oe high for 100 cycles; data bits after edges 1..8 are 1,0,1,1,0,1,1,1; parity 1 (data_oe=0); tx_done pulse with tx_ack_ok=1; tx_ready returns to 1.
- Send 0x00 -> parity bit 1; send 0xFF -> parity bit 0; both complete with tx_ack_ok=1.
- Device does not drive ack -> tx_done=1, tx_ack_ok=0.
- tx_valid held high throughout, with tx_data changed mid-frame -> only the first byte is sent; the second frame starts only after DONE.
- rst_n=0 at edge 5 -> next cycle both oe=0 and tx_ready=1; a new 0xF4 send then completes correctly.
- With PS2_HOST_TX_TIMEOUT_EN, TIMEOUT_MS=1, and the device silent -> tx_error pulses 1000 cycles after REQUEST, tx_done stays 0, lines are released.
